irdecoder_fifo_wb8: RTL and testbench
=====================================

# irdecoder_fifo_wb8

NEC infrared remote decoder with an 8-bit Wishbone slave interface.
- Measures filtered space (high) intervals and classifies each one as leader, bit 0, bit 1, repeat or stop.
- Validates complete 32-bit frames and queues them in a parametrised FIFO.
- Counts repeat codes and raises a maskable interrupt.
- Sits on the CPU's 8-bit peripheral bus beside the other Wishbone-8 peripherals and takes the raw output of an IR receiver module (idle high).

## Interface
- CLOCKFREQ, 25000000: clock frequency in Hz. MICROCYCLES = CLOCKFREQ/1000000 - 1.
- FIFODEPTH, 4: frame FIFO entries. Must be a power of two, at least 2.
- FILTERLEN, 3: glitch-filter length in samples, at least 2.
- CHECK_INVERSE, 1: when 1, reject frames where irdata[15:8] != ~irdata[7:0].
- REPEAT_US, 120000: window in µs, after a valid frame or repeat, in which a repeat code is accepted.
- I_wb_clk  in  1  clock. One clock only.
- I_reset  in  1  reset. Synchronous, active-high.
- I_wb_adr  in  3  register address.
- I_wb_dat  in  8  write data.
- I_wb_stb  in  1  strobe.
- I_wb_we  in  1  write enable.
- O_wb_ack  out  1  acknowledge. Reset value 0.
- O_wb_dat  out  8  read data. Reset value 0x00.
- I_ir_signal  in  1  raw receiver output. Asynchronous to the clock, idle high.
- O_irq  out  1  interrupt, registered. Reset value 0.

## Operation
- **Filter:** I_ir_signal shifts into a FILTERLEN-bit register. The filtered level changes only when all bits agree. The filtered level resets to 1.
- **Interval counter:** counts cycles while the filtered level is high and saturates at COUNT_STOP. It clears on the cycle the filtered level goes low.
- **Thresholds (cycles):**
  - COUNT_0 = 400·MICROCYCLES
  - COUNT_1 = 1400·MICROCYCLES
  - COUNT_SHORT = 2000·MICROCYCLES
  - COUNT_LONG = 4000·MICROCYCLES
  - COUNT_STOP = 8000·MICROCYCLES
- **Classification of count c at a high→low edge:**
  - c < COUNT_0: GLITCH
  - c < COUNT_1: ZERO
  - c < COUNT_SHORT: ONE
  - c < COUNT_LONG: REPEAT
  - otherwise: START
- **State machine (IDLE, DATA):**
  - IDLE + START → DATA, bitcount = 0.
  - IDLE + REPEAT with repeat_ok set → repeat event: repeat counter +1 (saturates at 255), sticky bit 3 set, repeat window restarted.
  - DATA + ZERO/ONE → irdata = {irdata[30:0], bit}, bitcount + 1. At 32 bits → frame complete, go to IDLE.
  - DATA + GLITCH or REPEAT → abort to IDLE, repeat_ok cleared.
  - DATA + START → restart, bitcount = 0.
  - Counter reaching COUNT_STOP in any state → IDLE. repeat_ok is not affected.
  - repeat_ok clears when REPEAT_US·MICROCYCLES cycles pass without a valid frame or repeat.
- **Frame complete:**
  - Inverse check failing → frame dropped, sticky checkerr set, repeat_ok cleared.
  - Inverse check passing → push to FIFO, set repeat_ok, clear repeat counter.
  - FIFO full → frame dropped, sticky overflow set.
- **Register map:**
  - 0 R: status {3'b0, checkerr, repeat, overflow, full, notempty}. W: write 1 to clear bits 4:2.
  - 1 R: pop the FIFO head into a 24-bit readbuffer and return irdata[31:24]. If the FIFO is empty, return 0 and load readbuffer with 0.
  - 2, 3, 4 R: readbuffer[23:16], [15:8], [7:0].
  - 5 R: repeat counter. W: any value clears it.
  - 6 R/W: control {6'b0, repeat_irq_en, frame_irq_en}. Resets to 0.
  - 7 R: FIFO fill level, zero-extended.
  - Writes to read-only addresses are ignored.
- **Interrupt:** O_irq = (frame_irq_en & notempty) | (repeat_irq_en & repeat sticky).

## Timing
- **Wishbone access:** accepted on a cycle with I_wb_stb & !O_wb_ack. O_wb_ack is high for exactly one cycle on the next edge, and O_wb_dat is valid on that same cycle.
- **Side effects** (pop, clear) happen once per accepted access. Holding stb never causes a double pop.
- **Push latency:** the FIFO push is visible in status one cycle after the classifying edge. Edge detection lags the raw input by FILTERLEN cycles.
- **Simultaneous push and pop:** both happen and the level is unchanged. Push to a full FIFO while a pop is accepted in the same cycle → push succeeds, no overflow.
- **Simultaneous sticky set and W1C clear:** set wins.
- **Reset:** all state, FIFO, stickies, control and outputs clear. State goes to IDLE, filtered level goes to 1. Reset mid-frame discards the partial frame.

## Test plan
- Use CLOCKFREQ=2000000 (MICROCYCLES=1, COUNT_0=400) for all scenarios.
- Valid frame 0x00FFA25D → status 0x01. Reads of adr 1/2/3/4 return 0x00/0xFF/0xA2/0x5D. Status is then 0x00.
- Frame 0x00FFA25C with CHECK_INVERSE=1 → status 0x10, level 0, no push. A W1C of 0x10 to adr 0 → status 0x00.
- FIFODEPTH=4, five distinct valid frames → level 4, status 0x07. Four pops return frames 1–4 in order.
- Valid frame plus two repeat codes → adr 5 = 2, status bit 3 set, O_irq = 1 with control = 0x02. A repeat arriving after REPEAT_US → counter stays at 2.
- 1- and 2-cycle low pulses during spaces with FILTERLEN=3 → decoded frame unchanged.
- I_reset after 16 bits → all registers 0. The next full frame decodes correctly.
- Back-to-back reads to adr 1 with stb held for 3 cycles → only one pop per ack.

Source files
------------

// File: rtl/irdecoder_fifo_wb8.sv
// irdecoder_fifo_wb8 - NEC infrared remote decoder with an 8-bit Wishbone slave.
//
// Filters the raw IR receiver output, measures each high (space) interval and
// classifies it at the following falling edge. Complete 32-bit frames that pass
// the optional address/command inverse check are queued in a small FIFO.
// Repeat codes that arrive inside the repeat window are counted.
//
// Ports:
//   I_wb_clk     clock (the only clock)
//   I_reset      synchronous active-high reset
//   I_wb_adr     register address (0..7)
//   I_wb_dat     write data
//   I_wb_stb     bus strobe
//   I_wb_we      write enable
//   O_wb_ack     one-cycle acknowledge, returned on the edge after acceptance
//   O_wb_dat     read data, valid while O_wb_ack is high
//   I_ir_signal  raw receiver output, asynchronous, idle high
//   O_irq        registered interrupt request
//
// Registers:
//   0 R status {3'b0, checkerr, repeat, overflow, full, notempty}, W 1-to-clear [4:2]
//   1 R pop FIFO head, return irdata[31:24], low 24 bits go to the readbuffer
//   2..4 R readbuffer[23:16], [15:8], [7:0]
//   5 R repeat counter, W clears it
//   6 R/W control {6'b0, repeat_irq_en, frame_irq_en}
//   7 R FIFO fill level

module irdecoder_fifo_wb8 #(
   parameter int CLOCKFREQ     = 25000000,
   parameter int FIFODEPTH     = 4,
   parameter int FILTERLEN     = 3,
   parameter int CHECK_INVERSE = 1,
   parameter int REPEAT_US     = 120000
) (
   input  logic       I_wb_clk,
   input  logic       I_reset,
   input  logic [2:0] I_wb_adr,
   input  logic [7:0] I_wb_dat,
   input  logic       I_wb_stb,
   input  logic       I_wb_we,
   output logic       O_wb_ack,
   output logic [7:0] O_wb_dat,
   input  logic       I_ir_signal,
   output logic       O_irq
);

   localparam int MICROCYCLES = CLOCKFREQ / 1000000 - 1;
   localparam int COUNT_0     = 400  * MICROCYCLES;
   localparam int COUNT_1     = 1400 * MICROCYCLES;
   localparam int COUNT_SHORT = 2000 * MICROCYCLES;
   localparam int COUNT_LONG  = 4000 * MICROCYCLES;
   localparam int COUNT_STOP  = 8000 * MICROCYCLES;
   localparam int REPEAT_CYC  = REPEAT_US * MICROCYCLES;
   localparam int CW          = $clog2(COUNT_STOP + 1);
   localparam int RW          = $clog2(REPEAT_CYC + 1);
   localparam int AW          = $clog2(FIFODEPTH);

   typedef enum logic [2:0] {CL_GLITCH, CL_ZERO, CL_ONE, CL_REPEAT, CL_START} cls_t;
   typedef enum logic {S_IDLE, S_DATA} state_t;

   // ---------------------------------------------------------------------------
   // Glitch filter. The shift register also acts as the synchroniser for the
   // asynchronous input; the filtered level only moves when every tap agrees.
   // ---------------------------------------------------------------------------
   logic [FILTERLEN-1:0] filt_sr;
   logic                 ir_lvl;
   logic                 all_hi, all_lo, fall;

   assign all_hi = &filt_sr;
   assign all_lo = ~|filt_sr;
   assign fall   = ir_lvl & all_lo;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         filt_sr <= '1;
         ir_lvl  <= 1'b1;
      end else begin
         filt_sr <= {filt_sr[FILTERLEN-2:0], I_ir_signal};
         if (all_hi)
            ir_lvl <= 1'b1;
         else if (all_lo)
            ir_lvl <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Space interval counter, saturating at COUNT_STOP
   // ---------------------------------------------------------------------------
   logic [CW-1:0] cnt;
   logic          cnt_stop;

   assign cnt_stop = (cnt == CW'(COUNT_STOP));

   always_ff @(posedge I_wb_clk) begin
      if (I_reset)
         cnt <= '0;
      else if (fall)
         cnt <= '0;
      else if (ir_lvl && !cnt_stop)
         cnt <= cnt + CW'(1);
   end

   cls_t cls;

   always_comb begin
      if (cnt < CW'(COUNT_0))
         cls = CL_GLITCH;
      else if (cnt < CW'(COUNT_1))
         cls = CL_ZERO;
      else if (cnt < CW'(COUNT_SHORT))
         cls = CL_ONE;
      else if (cnt < CW'(COUNT_LONG))
         cls = CL_REPEAT;
      else
         cls = CL_START;
   end

   // ---------------------------------------------------------------------------
   // Frame state machine
   // ---------------------------------------------------------------------------
   state_t      state, state_nxt;
   logic [4:0]  bitcnt, bitcnt_nxt;
   logic [31:0] irdata, irdata_nxt;
   logic [31:0] frame_word;
   logic        frame_done, repeat_evt, abort;
   logic        rpt_ok;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         state  <= S_IDLE;
         bitcnt <= '0;
         irdata <= '0;
      end else begin
         state  <= state_nxt;
         bitcnt <= bitcnt_nxt;
         irdata <= irdata_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      bitcnt_nxt = bitcnt;
      irdata_nxt = irdata;
      frame_done = 1'b0;
      repeat_evt = 1'b0;
      abort      = 1'b0;
      frame_word = {irdata[30:0], cls == CL_ONE};
      if (fall) begin
         case (state)
            S_IDLE: begin
               if (cls == CL_START) begin
                  state_nxt  = S_DATA;
                  bitcnt_nxt = '0;
               end else if (cls == CL_REPEAT && rpt_ok) begin
                  repeat_evt = 1'b1;
               end
            end
            S_DATA: begin
               case (cls)
                  CL_ZERO, CL_ONE: begin
                     irdata_nxt = frame_word;
                     bitcnt_nxt = bitcnt + 5'd1;
                     if (bitcnt == 5'd31) begin
                        frame_done = 1'b1;
                        state_nxt  = S_IDLE;
                        bitcnt_nxt = '0;
                     end
                  end
                  CL_START: bitcnt_nxt = '0;
                  default: begin
                     abort     = 1'b1;
                     state_nxt = S_IDLE;
                  end
               endcase
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (cnt_stop) begin
         // line idle too long: any partial frame is abandoned
         state_nxt = S_IDLE;
      end
   end

   logic chk_ok, push_req, chk_fail;

   assign chk_ok   = (CHECK_INVERSE == 0) || (frame_word[15:8] == ~frame_word[7:0]);
   assign push_req = frame_done & chk_ok;
   assign chk_fail = frame_done & ~chk_ok;

   // ---------------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------------
   logic acc, rd, wr, pop, push, ovf_set;
   logic [AW:0] fill;
   logic full, notempty;

   assign acc      = I_wb_stb & ~O_wb_ack;
   assign rd       = acc & ~I_wb_we;
   assign wr       = acc & I_wb_we;
   assign full     = (fill == (AW+1)'(FIFODEPTH));
   assign notempty = (fill != '0);
   assign pop      = rd && (I_wb_adr == 3'd1) && notempty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push     = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;

   // ---------------------------------------------------------------------------
   // Frame FIFO
   // ---------------------------------------------------------------------------
   logic [31:0]   mem [FIFODEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [31:0]   head;

   assign head = mem[rptr];

   always_ff @(posedge I_wb_clk) begin
      if (push)
         mem[wptr] <= frame_word;
   end

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         wptr <= '0;
         rptr <= '0;
         fill <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Repeat tracking, stickies, control
   // ---------------------------------------------------------------------------
   logic [RW-1:0] rtmr;
   logic [7:0]    rpt_cnt;
   logic          checkerr, rpt_sticky, overflow;
   logic [1:0]    ctrl;
   logic [23:0]   rbuf;
   logic [2:0]    w1c;

   assign w1c = (wr && I_wb_adr == 3'd0) ? I_wb_dat[4:2] : 3'b000;

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         rpt_ok <= 1'b0;
         rtmr   <= '0;
      end else if (push_req || repeat_evt) begin
         rpt_ok <= 1'b1;
         rtmr   <= '0;
      end else if (chk_fail || abort) begin
         rpt_ok <= 1'b0;
         rtmr   <= '0;
      end else if (rpt_ok) begin
         if (rtmr == RW'(REPEAT_CYC - 1)) begin
            rpt_ok <= 1'b0;
            rtmr   <= '0;
         end else begin
            rtmr <= rtmr + RW'(1);
         end
      end
   end

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         rpt_cnt    <= '0;
         checkerr   <= 1'b0;
         rpt_sticky <= 1'b0;
         overflow   <= 1'b0;
         ctrl       <= '0;
         rbuf       <= '0;
      end else begin
         if (repeat_evt) begin
            if (rpt_cnt != 8'hFF)
               rpt_cnt <= rpt_cnt + 8'd1;
         end else if (push_req || (wr && I_wb_adr == 3'd5)) begin
            rpt_cnt <= '0;
         end
         // setting beats a simultaneous write-1-to-clear
         checkerr   <= chk_fail   | (checkerr   & ~w1c[2]);
         rpt_sticky <= repeat_evt | (rpt_sticky & ~w1c[1]);
         overflow   <= ovf_set    | (overflow   & ~w1c[0]);
         if (wr && I_wb_adr == 3'd6)
            ctrl <= I_wb_dat[1:0];
         if (rd && I_wb_adr == 3'd1)
            rbuf <= notempty ? head[23:0] : 24'h0;
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux, bus outputs, interrupt
   // ---------------------------------------------------------------------------
   logic [7:0] rdata;

   always_comb begin
      rdata = 8'h00;
      case (I_wb_adr)
         3'd0: rdata = {3'b000, checkerr, rpt_sticky, overflow, full, notempty};
         3'd1: rdata = notempty ? head[31:24] : 8'h00;
         3'd2: rdata = rbuf[23:16];
         3'd3: rdata = rbuf[15:8];
         3'd4: rdata = rbuf[7:0];
         3'd5: rdata = rpt_cnt;
         3'd6: rdata = {6'b000000, ctrl};
         3'd7: rdata = 8'(fill);
         default: rdata = 8'h00;
      endcase
   end

   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         O_wb_ack <= 1'b0;
         O_wb_dat <= 8'h00;
         O_irq    <= 1'b0;
      end else begin
         O_wb_ack <= acc;
         if (rd)
            O_wb_dat <= rdata;
         O_irq <= (ctrl[0] & notempty) | (ctrl[1] & rpt_sticky);
      end
   end

   logic unused_bits;
   assign unused_bits = ^I_wb_dat[7:5];

endmodule

// File: tb/tb_irdecoder_fifo_wb8.sv
// Self-checking bench for irdecoder_fifo_wb8: drives NEC-style space timings on
// the IR input, accesses registers over Wishbone and compares against a queue
// based reference of frames, stickies and the repeat counter.

module tb_irdecoder_fifo_wb8;

   localparam int DEPTH  = 4;
   localparam int REP_US = 3200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] adr = 3'd0;
   logic [7:0] wdat = 8'h00;
   logic       stb = 1'b0;
   logic       we = 1'b0;
   logic       ir = 1'b1;
   logic       ack;
   logic [7:0] rdat;
   logic       irq;

   always #5 clk = ~clk;

   irdecoder_fifo_wb8 #(
      .CLOCKFREQ(2000000), .FIFODEPTH(DEPTH), .FILTERLEN(3),
      .CHECK_INVERSE(1), .REPEAT_US(REP_US)
   ) dut (
      .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_dat(wdat),
      .I_wb_stb(stb), .I_wb_we(we), .O_wb_ack(ack), .O_wb_dat(rdat),
      .I_ir_signal(ir), .O_irq(irq)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] exp_q[$];
   bit m_chk = 0, m_ovf = 0, m_rep = 0, m_rok = 0;
   int m_rcnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_status();
      return {3'b000, m_chk, m_rep, m_ovf, exp_q.size() == DEPTH, exp_q.size() != 0};
   endfunction

   function automatic void model_frame(input logic [31:0] w);
      if (w[15:8] != ~w[7:0]) begin
         m_chk = 1;
         m_rok = 0;
      end else begin
         m_rok  = 1;
         m_rcnt = 0;
         if (exp_q.size() < DEPTH) exp_q.push_back(w);
         else m_ovf = 1;
      end
   endfunction

   function automatic void model_repeat(input bit in_window);
      if (m_rok && in_window) begin
         if (m_rcnt < 255) m_rcnt++;
         m_rep = 1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ir = 1'b1;
      repeat (n) tick();
   endtask

   // high interval of n cycles (optionally with 1- and 2-cycle dropouts), then a mark
   task automatic space(input int n, input bit glitch);
      int mark;
      mark = $urandom_range(4, 12);
      for (int k = 0; k < n; k++) begin
         if (glitch && (k == n / 3 || k == 2 * n / 3 || k == 2 * n / 3 + 1)) ir = 1'b0;
         else ir = 1'b1;
         tick();
      end
      ir = 1'b0;
      repeat (mark) tick();
   endtask

   task automatic send_bits(input logic [31:0] w, input int nb, input bit glitch);
      space(4100, glitch);
      for (int b = 31; b > 31 - nb; b--) space(w[b] ? 1420 : 420, glitch);
   endtask

   task automatic wb_rd(input logic [2:0] a, output logic [7:0] d);
      adr = a; we = 1'b0; stb = 1'b1;
      tick();
      chk("rd_ack", 32'(ack), 1);
      d = rdat;
      stb = 1'b0;
      tick();
   endtask

   task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
      adr = a; we = 1'b1; wdat = d; stb = 1'b1;
      tick();
      chk("wr_ack", 32'(ack), 1);
      stb = 1'b0; we = 1'b0;
      tick();
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] e);
      logic [7:0] d;
      wb_rd(a, d);
      chk(tag, 32'(d), 32'(e));
   endtask

   task automatic chk_all_zero(input string tag);
      for (int a = 0; a < 8; a++) chk_reg($sformatf("%s_adr%0d", tag, a), 3'(a), 8'h00);
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] f;
      f = exp_q.pop_front();
      chk_reg({tag, "_b3"}, 3'd1, f[31:24]);
      chk_reg({tag, "_b2"}, 3'd2, f[23:16]);
      chk_reg({tag, "_b1"}, 3'd3, f[15:8]);
      chk_reg({tag, "_b0"}, 3'd4, f[7:0]);
   endtask

   initial begin
      logic [31:0] fa, fb, f2, f3, fr[4];
      logic [7:0]  c, d1, d3;
      logic        a1, a2, a3;

      // reset values
      repeat (3) tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_dat", 32'(rdat), 0);
      chk("rst_irq", 32'(irq), 0);
      rst = 1'b0;
      tick();
      chk_all_zero("init");

      // partial frame, reset mid-frame
      fa = 32'h00FFA25D;
      send_bits(32'h5A00_FF00 ^ $urandom_range(0, 255), 16, 0);
      idle(100);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk_all_zero("midrst");

      // first valid frame decodes after the reset
      send_bits(fa, 32, 0);
      model_frame(fa);
      idle(20);
      chk_reg("st_one", 3'd0, exp_status());
      chk_reg("lvl_one", 3'd7, 8'(exp_q.size()));
      wb_wr(3'd6, 8'h01);
      chk("irq_frame", 32'(irq), 1);
      wb_wr(3'd6, 8'h00);
      chk("irq_off", 32'(irq), 0);

      // three more random frames (first one with filter glitches) fill the FIFO
      for (int i = 0; i < 4; i++) begin
         c = 8'($urandom);
         fr[i] = {8'(1 << i), 8'h00, ~c, c};
      end
      for (int i = 0; i < 3; i++) begin
         send_bits(fr[i], 32, i == 0);
         model_frame(fr[i]);
      end
      idle(10);
      chk_reg("st_full", 3'd0, exp_status());

      // two repeat codes inside the window
      space(2500, 0); model_repeat(1);
      space(2500, 0); model_repeat(1);
      idle(10);
      chk_reg("rcnt_two", 3'd5, 8'(m_rcnt));
      chk_reg("st_rep", 3'd0, exp_status());
      wb_wr(3'd6, 8'h02);
      chk("irq_rep", 32'(irq), 1);

      // let the window expire with spaces that do nothing in IDLE, then a repeat
      for (int i = 0; i < 4; i++) space(1000, 0);
      space(2500, 0); model_repeat(0);
      idle(10);
      chk_reg("rcnt_late", 3'd5, 8'(m_rcnt));
      wb_wr(3'd6, 8'h00);

      // fifth frame overflows
      send_bits(fr[3], 32, 0);
      model_frame(fr[3]);
      idle(20);
      chk_reg("st_ovf", 3'd0, exp_status());
      chk_reg("lvl_ovf", 3'd7, 8'(exp_q.size()));
      wb_wr(3'd0, 8'h1C);
      m_ovf = 0; m_rep = 0;
      chk_reg("st_w1c", 3'd0, exp_status());

      // pops: normal, then two with stb held for three cycles, then normal
      pop_check("pop1");
      f2 = exp_q.pop_front();
      f3 = exp_q.pop_front();
      adr = 3'd1; we = 1'b0; stb = 1'b1;
      tick(); a1 = ack; d1 = rdat;
      tick(); a2 = ack;
      tick(); a3 = ack; d3 = rdat;
      stb = 1'b0;
      tick();
      chk("hold_ack1", 32'(a1), 1);
      chk("hold_ack2", 32'(a2), 0);
      chk("hold_ack3", 32'(a3), 1);
      chk("hold_pop2", 32'(d1), 32'(f2[31:24]));
      chk("hold_pop3", 32'(d3), 32'(f3[31:24]));
      chk_reg("hold_buf", 3'd4, f3[7:0]);
      chk_reg("hold_lvl", 3'd7, 8'(exp_q.size()));
      pop_check("pop4");
      chk_reg("st_empty", 3'd0, exp_status());
      chk_reg("pop_empty", 3'd1, 8'h00);
      chk_reg("buf_empty", 3'd2, 8'h00);

      // inverse check failure
      fb = 32'h00FFA25C;
      send_bits(fb, 32, 0);
      model_frame(fb);
      idle(20);
      chk_reg("st_chkerr", 3'd0, exp_status());
      chk_reg("lvl_chkerr", 3'd7, 8'(exp_q.size()));
      wb_wr(3'd0, 8'h10);
      m_chk = 0;
      chk_reg("st_clr", 3'd0, exp_status());

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
